// File: rtl/mdio_phy_init_seq.sv
// Table-driven MDIO PHY init sequencer: power-up delay, command table, then optional link polling.
// Define MDIO_PHY_INIT_SEQ_VERIFY_EN to read back and retry every table write.
module mdio_phy_init_seq #(
  parameter int unsigned NUM_CMDS = 2,
  parameter logic [4:0] PHY_ADDR = 5'h00,
  parameter logic [NUM_CMDS*23-1:0] CMD_TABLE = {23'h201340, 23'h290000},
  parameter int unsigned DELAY_CYCLES = 65535,
  parameter int unsigned POLL_EN = 1,
  parameter int unsigned POLL_INTERVAL = 1_000_000,
  parameter int unsigned RESP_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic [4:0] cmd_phy_addr,
  output logic [4:0] cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0] cmd_opcode,
  output logic cmd_valid,
  input  logic cmd_ready,
  input  logic [15:0] data_out,
  input  logic data_out_valid,
  output logic data_out_ready,
  output logic busy,
  output logic done,
  output logic link_up,
  output logic error,
  output logic [$clog2(NUM_CMDS+1)-1:0] cmd_index
);

  localparam int unsigned ENTRY_W = 23;
  localparam int unsigned CI_W = $clog2(NUM_CMDS + 1);
  localparam int unsigned DLY_W = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam int unsigned POLL_LAST = (POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0;
  localparam int unsigned PW = (POLL_LAST > 0) ? $clog2(POLL_LAST + 1) : 1;
  localparam int unsigned RESP_LAST = (RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0;
  localparam int unsigned RW = (RESP_LAST > 0) ? $clog2(RESP_LAST + 1) : 1;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [2:0] {
    S_DELAY,
    S_ISSUE,
    S_XFER,
    S_POLL_WAIT,
    S_IDLE
  } state_t;

  state_t state;
  logic [DLY_W-1:0] dly_cnt;
  logic [PW-1:0] poll_cnt;
  logic [RW-1:0] resp_cnt;
  logic polling;
  logic restart_pend;
  logic [ENTRY_W-1:0] entry;
  logic unused;

`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
  // Bit 15 (reset) and bit 9 (autoneg restart) self-clear, so they never read back.
  localparam logic [15:0] VERIFY_MASK = 16'h7DFF;
  logic verifying;
  logic [1:0] attempts;
`endif

  assign cmd_phy_addr = PHY_ADDR;
  assign data_out_ready = 1'b1;
  assign unused = ^{data_out[15:3], data_out[1:0]};

  // Table entry selected by the current index.
  always_comb begin
    entry = '0;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (cmd_index == CI_W'(i)) entry = CMD_TABLE[i*ENTRY_W +: ENTRY_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DELAY;
      dly_cnt <= DLY_W'(DELAY_CYCLES);
      poll_cnt <= '0;
      resp_cnt <= '0;
      polling <= 1'b0;
      restart_pend <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_opcode <= OP_WRITE;
      cmd_reg_addr <= '0;
      cmd_data <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      link_up <= 1'b0;
      error <= 1'b0;
      cmd_index <= '0;
`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
      verifying <= 1'b0;
      attempts <= '0;
`endif
    end else if (((start && !busy) || restart_pend) && !cmd_valid) begin
      // Restart only once no command is outstanding on the bus.
      state <= S_DELAY;
      dly_cnt <= DLY_W'(DELAY_CYCLES);
      polling <= 1'b0;
      restart_pend <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      cmd_index <= '0;
`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
      verifying <= 1'b0;
      attempts <= '0;
`endif
    end else begin
      if (start && !busy) restart_pend <= 1'b1;
      case (state)
        S_DELAY: begin
          if (dly_cnt == '0) state <= S_ISSUE;
          else dly_cnt <= dly_cnt - 1'b1;
        end
        S_ISSUE: begin
          if (!polling && cmd_index == CI_W'(NUM_CMDS)) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (POLL_EN != 0) begin
              polling <= 1'b1;
              poll_cnt <= '0;
              state <= S_POLL_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end else if (cmd_ready) begin
            cmd_valid <= 1'b1;
            state <= S_XFER;
            if (polling) begin
              cmd_opcode <= OP_READ;
              cmd_reg_addr <= 5'd1;
              cmd_data <= '0;
            end
`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
            else if (verifying) begin
              cmd_opcode <= OP_READ;
              cmd_reg_addr <= entry[20:16];
              cmd_data <= '0;
            end
`endif
            else begin
              cmd_opcode <= entry[22:21];
              cmd_reg_addr <= entry[20:16];
              cmd_data <= entry[15:0];
            end
          end
        end
        S_XFER: begin
          if (cmd_valid) begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              resp_cnt <= '0;
              if (cmd_opcode != OP_READ) begin
`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
                verifying <= 1'b1;
`else
                cmd_index <= cmd_index + 1'b1;
`endif
                state <= S_ISSUE;
              end
            end
          end else if (data_out_valid || resp_cnt == RW'(RESP_LAST)) begin
            // Read finished: either data arrived or the timeout expired.
            state <= S_ISSUE;
            if (polling) begin
              state <= S_POLL_WAIT;
              poll_cnt <= '0;
              if (data_out_valid) link_up <= data_out[2];
              else error <= 1'b1;
            end
`ifdef MDIO_PHY_INIT_SEQ_VERIFY_EN
            else if (verifying) begin
              verifying <= 1'b0;
              if (data_out_valid && ((data_out ^ entry[15:0]) & VERIFY_MASK) == '0) begin
                cmd_index <= cmd_index + 1'b1;
                attempts <= '0;
              end else if (attempts == 2'd2) begin
                error <= 1'b1;
                cmd_index <= cmd_index + 1'b1;
                attempts <= '0;
              end else begin
                attempts <= attempts + 1'b1;
              end
            end
`endif
            else begin
              if (!data_out_valid) error <= 1'b1;
              cmd_index <= cmd_index + 1'b1;
            end
          end else begin
            resp_cnt <= resp_cnt + 1'b1;
          end
        end
        S_POLL_WAIT: begin
          if (poll_cnt == PW'(POLL_LAST)) state <= S_ISSUE;
          else poll_cnt <= poll_cnt + 1'b1;
        end
        S_IDLE: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_init_seq.sv
// Self-checking bench for mdio_phy_init_seq: a small mdio_master model with random ready/latency,
// checked against the command table and link rules computed directly from the parameters.
module tb_mdio_phy_init_seq;

  localparam int N = 3;
  localparam logic [N*23-1:0] TBL = {23'h201340, 23'h420000, 23'h290000};
  localparam int DLY = 16;
  localparam int PI = 100;
  localparam int RT = 32;
  localparam logic [4:0] PA = 5'h05;

  logic clk, rst_n, start;
  logic [4:0] cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_data, data_out;
  logic [1:0] cmd_opcode;
  logic cmd_valid, cmd_ready, data_out_valid, data_out_ready;
  logic busy, done, link_up, error;
  logic [$clog2(N+1)-1:0] cmd_index;

  mdio_phy_init_seq #(
    .NUM_CMDS(N), .PHY_ADDR(PA), .CMD_TABLE(TBL), .DELAY_CYCLES(DLY),
    .POLL_EN(1), .POLL_INTERVAL(PI), .RESP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .cmd_opcode(cmd_opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .busy(busy), .done(done), .link_up(link_up), .error(error), .cmd_index(cmd_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] phy;
    logic [4:0] rg;
    logic [1:0] op;
    logic [15:0] d;
    int cyc;
  } cmd_t;

  cmd_t acc_q[$];
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: refuse while valid
  int resp_mode = 1;   // 0: answer reads after 1..4 cycles, 1: never answer
  logic [15:0] resp_data = '0;
  int resp_cnt = 0;
  int stall_cnt = 0;
  bit stall_req = 0;
  bit stall_valid_seen = 0;
  bit stall_idx_moved = 0;
  logic [$clog2(N+1)-1:0] stall_idx = '0;
  int err_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int v, input int lo, input int hi);
    ncmp++;
    assert (v >= lo && v <= hi) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  // mdio_master model plus handshake protocol monitor, evaluated at every falling edge.
  initial begin
    logic pv, phs, pr, hs;
    logic [22:0] pf;
    pv = 0; phs = 0; pr = 1; pf = '0;
    cmd_ready = 1'b1; data_out = '0; data_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv = 0; phs = 0; pr = 1; resp_cnt = 0; stall_cnt = 0;
        data_out_valid = 1'b0; cmd_ready = 1'b1;
      end else begin
        data_out_valid = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            data_out_valid = 1'b1;
            data_out = resp_data;
          end
        end
        if (pv && !phs) begin
          check("valid_hold", 32'(cmd_valid), 1);
          check("fields_hold", 32'({cmd_reg_addr, cmd_opcode, cmd_data}), 32'(pf));
        end
        if (phs) check("valid_drop_after_accept", 32'(cmd_valid), 0);
        if (cmd_valid && !pv) check("issue_only_when_ready", 32'(pr), 1);
        if (stall_cnt > 0) begin
          if (stall_cnt == 50) stall_idx = cmd_index;
          if (cmd_valid) stall_valid_seen = 1;
          if (cmd_index != stall_idx) stall_idx_moved = 1;
        end
        case (ready_mode)
          0: cmd_ready = 1'b1;
          1: cmd_ready = 1'($urandom_range(0, 1));
          default: cmd_ready = !cmd_valid;
        endcase
        if (stall_cnt > 0) begin
          cmd_ready = 1'b0;
          stall_cnt--;
        end
        hs = cmd_valid && cmd_ready;
        if (hs) begin
          acc_q.push_back('{cmd_phy_addr, cmd_reg_addr, cmd_opcode, cmd_data, cyc});
          if (cmd_opcode == 2'b10 && resp_mode == 0) resp_cnt = int'($urandom_range(1, 4));
          if (stall_req) begin
            stall_req = 0;
            stall_cnt = 50;
          end
        end
        pv = cmd_valid; phs = hs; pr = cmd_ready;
        pf = {cmd_reg_addr, cmd_opcode, cmd_data};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    err_cyc = -1;
    while (!done && n < budget) begin
      tick();
      n++;
      if (error && err_cyc < 0) err_cyc = cyc;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic compare_table(input string tag);
    logic [N*23-1:0] t;
    logic [22:0] e;
    check({tag, "_count"}, acc_q.size(), N);
    for (int i = 0; i < N && i < acc_q.size(); i++) begin
      t = TBL >> (23 * i);
      e = t[22:0];
      check($sformatf("%s_cmd%0d", tag, i),
            32'({acc_q[i].phy, acc_q[i].rg, acc_q[i].op, acc_q[i].d}),
            32'({PA, e[20:16], e[22:21], e[15:0]}));
    end
  endtask

  // One link poll: reg 1 read, link_up follows bit 2 of the returned word.
  task automatic poll_once(input logic [15:0] d, input string tag);
    int k = acc_q.size();
    int n = 0;
    resp_data = d;
    while (acc_q.size() <= k && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_poll_seen"}, 32'(acc_q.size() > k), 1);
    if (acc_q.size() > k) begin
      check({tag, "_poll_cmd"}, 32'({acc_q[k].phy, acc_q[k].rg, acc_q[k].op}), 32'({PA, 5'd1, 2'b10}));
      if (k > 3) check_range({tag, "_poll_interval"}, acc_q[k].cyc - acc_q[k-1].cyc, PI + 1, PI + 10);
    end
    repeat (8) tick();
    check({tag, "_link_up"}, 32'(link_up), 32'(d[2]));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_fields", 32'({cmd_opcode, cmd_reg_addr, cmd_data}), 32'({2'b01, 5'd0, 16'd0}));
    check("rst_status", 32'({busy, done, link_up, error}), 32'(4'b1000));
    check("rst_index", 32'(cmd_index), 0);
    check("const_outputs", 32'({cmd_phy_addr, data_out_ready}), 32'({PA, 1'b1}));

    // Table run with the read entry never answered: timeout, error, sequence continues.
    rst_n = 1'b1;
    n = 0;
    while (!cmd_valid && n < 100) begin
      tick();
      n++;
    end
    check_range("first_valid_latency", n, DLY + 1, DLY + 2);
    wait_done(400);
    compare_table("run1");
    if (acc_q.size() > 1) check_range("read_timeout_latency", err_cyc - acc_q[1].cyc, RT, RT + 1);
    check("run1_end_status", 32'({busy, error, cmd_index}), 32'({1'b0, 1'b1, 2'd3}));

    // Link polling: directed words, then random ones.
    resp_mode = 0;
    poll_once(16'h796D, "p0");
    poll_once(16'h7949, "p1");
    for (int i = 0; i < 3; i++) poll_once(16'($urandom), $sformatf("pr%0d", i));

    // Restart after done, a second start while busy, a 50-cycle ready stall, then random ready.
    stall_req = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    tick();
    n++;
    check("restart_status", 32'({busy, done, cmd_index}), 32'({1'b1, 1'b0, 2'd0}));
    tick();
    n++;
    acc_q.delete();
    while (!cmd_valid && n < 200) begin
      tick();
      n++;
      if (n == 8) start = 1'b1;
      if (n == 9) start = 1'b0;
    end
    check_range("restart_latency", n, DLY + 3, DLY + 4);
    ready_mode = 1;
    wait_done(800);
    check("stall_no_valid", 32'(stall_valid_seen), 0);
    check("stall_index_stable", 32'({stall_idx_moved, stall_idx}), 32'({1'b0, 2'd1}));
    compare_table("run2");
    check("error_sticky", 32'(error), 1);

    // Reset while a poll read is held waiting for ready.
    ready_mode = 2;
    n = 0;
    while (!cmd_valid && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("held_valid_before_reset", 32'(cmd_valid), 1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_valid", 32'(cmd_valid), 0);
    check("reset_clears_status", 32'({busy, done, link_up, error}), 32'(4'b1000));
    ready_mode = 0;
    tick();
    acc_q.delete();
    rst_n = 1'b1;
    wait_done(400);
    compare_table("run3");
    check("run3_no_error", 32'(error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mdio_phy_init_seq.md
Name: mdio_phy_init_seq

Overview:
- Table-driven MDIO PHY configuration sequencer; drives the command/response interface of `mdio_master`.
- After reset, waits a power-up delay, then issues a parameterised list of MDIO commands to one PHY.
- Optionally polls PHY status register 1 and reports link state.
- Instantiated per PHY in board top levels; replaces hand-written per-board init state machines (e.g. 1G-capability disable plus autoneg restart).

Parameters:
- NUM_CMDS, 2, number of table entries (>=1).
- PHY_ADDR, 5'h00, PHY address used for every command.
- CMD_TABLE, {23'h201340, 23'h290000}, packed entries. Entry i = CMD_TABLE[i*23 +: 23]: [22:21] opcode (01 write, 10 read), [20:16] reg addr, [15:0] data. Default: entry0 writes reg 9 = 0x0000; entry1 writes reg 0 = 0x1340.
- DELAY_CYCLES, 65535, power-up wait in clk cycles.
- POLL_EN, 1, 1 = poll reg 1 after the table completes.
- POLL_INTERVAL, 1_000_000, clk cycles between polls.
- RESP_TIMEOUT, 4096, max cycles to wait for data_out_valid on a read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; reruns the sequence from the delay phase
- cmd_phy_addr  out  5  to mdio_master
- cmd_reg_addr  out  5  to mdio_master
- cmd_data  out  16  to mdio_master
- cmd_opcode  out  2  to mdio_master
- cmd_valid  out  1  to mdio_master
- cmd_ready  in  1  from mdio_master
- data_out  in  16  read data from mdio_master
- data_out_valid  in  1  read data valid
- data_out_ready  out  1  read data accept
- busy  out  1  sequence in progress (delay or table)
- done  out  1  table completed
- link_up  out  1  reg1 bit 2 from the last successful poll
- error  out  1  sticky; read timeout or verify failure
- cmd_index  out  $clog2(NUM_CMDS+1)  index of the current or next entry

Behaviour:
- Reset (async, rst_n low) values:
  - state = DELAY, delay counter = DELAY_CYCLES.
  - cmd_valid = 0, cmd_opcode = 01, cmd_reg_addr = 0, cmd_data = 0.
  - busy = 1, done = 0, link_up = 0, error = 0, cmd_index = 0.
  - cmd_phy_addr is constantly PHY_ADDR. data_out_ready is constantly 1.
- DELAY: counter decrements once per cycle. When the counter is 0, go to ISSUE on the next cycle. DELAY_CYCLES = 0 reaches ISSUE one cycle after reset release.
- ISSUE: wait for cmd_ready = 1. Then load entry[cmd_index] into cmd_* and assert cmd_valid. Go to WAIT.
- Handshake: cmd_valid holds, with cmd_* stable, until the cycle where cmd_valid & cmd_ready; it deasserts on the next cycle. cmd_valid is never asserted while cmd_ready = 0 at issue time.
- WAIT, write entry: after acceptance, cmd_index increments and the state returns to ISSUE.
- WAIT, read entry: wait for data_out_valid; the data is discarded. If the wait exceeds RESP_TIMEOUT cycles, set error and advance anyway.
- Table end: when cmd_index == NUM_CMDS, set done = 1 and busy = 0. Go to POLL_WAIT if POLL_EN, else IDLE.
- POLL_WAIT: count POLL_INTERVAL cycles, then issue a read of reg 1 (opcode 10) using the same handshake.
  - On data_out_valid: link_up <= data_out[2].
  - On timeout: set error; link_up unchanged.
  - Return to POLL_WAIT.
- start, when not busy: clear done and cmd_index, set busy, reload the delay counter, go to DELAY. error stays sticky; only reset clears it.
- start while busy: ignored.
- start in the same cycle as a cmd_valid handshake completing: the handshake completes; the restart applies on the next cycle.
- Reset mid-transaction: cmd_valid drops immediately. mdio_master shares the same reset source, so no transaction is left half-owned.

Optional Feature:
- Macro: MDIO_PHY_INIT_SEQ_VERIFY_EN
- Defined:
  - After each write entry is accepted, the block issues a read of the same register and compares the result against the written data, excluding bit 15 (self-clearing reset) and bit 9 (autoneg restart).
  - Mismatch: rewrite the entry, up to 3 attempts, then set error and advance.
  - A readback timeout counts as a mismatch.
- Undefined: writes are fire-and-forget; no readback logic is synthesised.

Test Plan:
- Default table, DELAY_CYCLES = 16, cmd_ready = 1 → the first cmd_valid rises 17–18 cycles after rst_n rises, with reg 9 and data 0x0000; then reg 0 and data 0x1340; done = 1 after the second handshake.
- Hold cmd_ready = 0 for 50 cycles mid-table → cmd_valid stays 0 and cmd_index is stable; the sequence resumes exactly one command per ready window.
- POLL_EN = 1, POLL_INTERVAL = 100, model returns 0x796D → link_up = 1. The next poll returns 0x7949 → link_up = 0.
- Read entry where data_out_valid never arrives, RESP_TIMEOUT = 32 → error = 1 after 32 cycles; the next entry is issued; done is still reached.
- start pulse while busy → ignored. start pulse after done → done falls, busy rises, and the full table is reissued after DELAY_CYCLES.
- rst_n asserted while cmd_valid = 1 → cmd_valid is 0 in the same cycle; after release the table restarts from entry 0.
